// File: rtl/symbol_reorder_pkg.sv
// Shared types and helpers for the symbol reorderer.
// Contents: the drain-side state type, default parameter values, and the
// counter-width helper used for the fill and drain counters.
package symbol_reorder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  localparam int SYM_W_DEF         = 2;
  localparam int SYMS_PER_WORD_DEF = 4;

  // Width of a counter that indexes 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/symbol_word_buf.sv
// One word buffer of N symbols.
// Ports: clk/rst; write port (wr_en, wr_idx, wr_dat) plus the per-word order bit
// (wr_order_en, wr_order); read port rd_idx -> rd_dat, where rd_idx counts output order.
module symbol_word_buf
  import symbol_reorder_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int N     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [cnt_width(N)-1:0]        wr_idx,
  input  logic [SYM_W-1:0]               wr_dat,
  input  logic                           wr_order_en,
  input  logic                           wr_order,
  input  logic [cnt_width(N)-1:0]        rd_idx,
  output logic [SYM_W-1:0]               rd_dat
);

  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  logic [SYM_W-1:0] mem [N];
  logic             order;
  logic [CNT_W-1:0] slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      order <= 1'b0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_dat;
      // The order travels with the word, so a later frame cannot change it.
      if (wr_order_en) order <= wr_order;
    end
  end

  assign slot   = order ? (LAST_IDX - rd_idx) : rd_idx;
  assign rd_dat = mem[slot];

endmodule

// File: rtl/symbol_reorder.sv
// Groups a symbol stream into N-symbol words and re-emits each word reversed or in order.
// Ports: clk, rst; rev order select; axiiv/axiid input stream; axiov/axiod output stream,
// axiolast on the last symbol of a frame's last full word, axioerr pulse on a partial word.
module symbol_reorder
  import symbol_reorder_pkg::*;
#(
  parameter int SYM_W         = SYM_W_DEF,
  parameter int SYMS_PER_WORD = SYMS_PER_WORD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rev,
  input  logic             axiiv,
  input  logic [SYM_W-1:0] axiid,
  output logic             axiov,
  output logic [SYM_W-1:0] axiod,
  output logic             axiolast,
  output logic             axioerr
);

  localparam int N     = SYMS_PER_WORD;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  // Load side
  logic             prev_vld;
  logic             frame_rev;
  logic [CNT_W-1:0] fill;
  logic             wr_sel;
  logic             first_sym;
  logic             cur_rev;
  logic             word_done;

  // Drain side
  drain_state_t     state, state_nxt;
  logic             rd_sel;
  logic [CNT_W-1:0] rd_cnt;
  logic             end_flag;
  logic             ov_nxt;
  logic [SYM_W-1:0] od_nxt;
  logic             last_nxt;

  logic [SYM_W-1:0] a_dat, b_dat;

  assign first_sym = axiiv & ~prev_vld;
  assign cur_rev   = first_sym ? rev : frame_rev;
  assign word_done = axiiv && (fill == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_vld  <= 1'b0;
      frame_rev <= 1'b0;
      fill      <= '0;
      wr_sel    <= 1'b0;
      axioerr   <= 1'b0;
    end else begin
      prev_vld <= axiiv;
      // A nonzero fill at the first idle sample means the frame left a partial word.
      axioerr  <= !axiiv && (fill != '0);
      if (first_sym) frame_rev <= rev;
      if (axiiv) begin
        if (word_done) begin
          fill   <= '0;
          wr_sel <= ~wr_sel;
        end else begin
          fill <= fill + 1'b1;
        end
      end else begin
        fill <= '0;
      end
    end
  end

  symbol_word_buf #(.SYM_W(SYM_W), .N(N)) u_buf_a (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (axiiv && !wr_sel),
    .wr_idx      (fill),
    .wr_dat      (axiid),
    .wr_order_en (axiiv && !wr_sel && (fill == '0)),
    .wr_order    (cur_rev),
    .rd_idx      (rd_cnt),
    .rd_dat      (a_dat)
  );

  symbol_word_buf #(.SYM_W(SYM_W), .N(N)) u_buf_b (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (axiiv && wr_sel),
    .wr_idx      (fill),
    .wr_dat      (axiid),
    .wr_order_en (axiiv && wr_sel && (fill == '0)),
    .wr_order    (cur_rev),
    .rd_idx      (rd_cnt),
    .rd_dat      (b_dat)
  );

  // Drain FSM: state register (plus drain datapath and registered outputs)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_sel   <= 1'b0;
      rd_cnt   <= '0;
      end_flag <= 1'b0;
      axiov    <= 1'b0;
      axiod    <= '0;
      axiolast <= 1'b0;
    end else begin
      state    <= state_nxt;
      axiov    <= ov_nxt;
      axiod    <= od_nxt;
      axiolast <= last_nxt;
      if (word_done) begin
        rd_sel   <= wr_sel;
        rd_cnt   <= '0;
        end_flag <= 1'b0;
      end else if (state == DRAIN) begin
        rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + 1'b1;
        // Sticky: the frame may end any time during this word's drain.
        if (!axiiv) end_flag <= 1'b1;
      end
    end
  end

  // Drain FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (word_done) state_nxt = DRAIN;
      DRAIN:   if ((rd_cnt == LAST_IDX) && !word_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Drain FSM: outputs
  always_comb begin
    ov_nxt   = 1'b0;
    od_nxt   = '0;
    last_nxt = 1'b0;
    if (state == DRAIN) begin
      ov_nxt   = 1'b1;
      od_nxt   = rd_sel ? b_dat : a_dat;
      // The frame end may be seen on this very edge, hence the live axiiv term.
      last_nxt = (rd_cnt == LAST_IDX) && (end_flag || !axiiv);
    end
  end

endmodule

// File: doc/symbol_reorder.md
# symbol_reorder

Parametrised successor to the fixed dibit reorderer in the Ethernet receive path.
- Accepts a contiguous stream of SYM_W-bit symbols and groups them into words of SYMS_PER_WORD symbols.
- Re-emits each word with its symbol order reversed, or in arrival order, using a ping-pong buffer.
- Adds frame-end marking and partial-word error reporting.
- Sits between the RMII receive front end and the CRC/framing logic.

## Interface
- SYM_W, 2, bits per symbol (≥1)
- SYMS_PER_WORD, 4, symbols per word (≥2)
- clk  input  1  system clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- rev  input  1  1 = reverse symbol order within word, 0 = pass through in arrival order; sampled on first valid symbol of a frame
- axiiv  input  1  input symbol valid; high for the whole frame, low between frames
- axiid  input  SYM_W  input symbol
- axiov  output  1  output symbol valid
- axiod  output  SYM_W  output symbol
- axiolast  output  1  high with the final output symbol of a frame
- axioerr  output  1  one-cycle pulse: frame ended with a partial word

## Operation
- Frame: maximal run of cycles with axiiv=1. Symbol index within frame counts from 0; word k holds indices k·N..k·N+N−1, with N=SYMS_PER_WORD.
- Two word buffers A and B alternate. Word 0 loads into A, word 1 into B, and so on.
- While a buffer loads, the other drains one symbol per cycle.
- Drain order:
  - rev=1: slot N−1 down to 0.
  - rev=0: slot 0 up to N−1.
- rev is latched per frame; changes mid-frame are ignored.
- Only complete words are emitted. A partial word (frame ends after 1..N−1 symbols of a word) is discarded, and axioerr pulses once.
- axiolast marks the last symbol of the last complete word of a frame.
  - The frame-ended flag is sticky during drain, so a drop detected mid-drain still marks the draining word.
- A frame with fewer than N symbols emits nothing; it only produces axioerr.
- States, per drain side: IDLE, DRAIN.
  - IDLE→DRAIN when a word completes.
  - DRAIN→DRAIN when another word completes on the drain's final cycle.
  - DRAIN→IDLE after the N-th output symbol otherwise.
- Loading side tracks a fill counter 0..N−1 and a buffer-select bit. The fill counter clears on axiiv=0.
- Back-to-back frames:
  - A new frame may start one cycle after axiiv falls, while the previous word still drains.
  - The new frame loads the non-draining buffer.
  - The new frame's rev latch must not alter the drain order of the previous frame's word; the order is held per buffer.
- Reset asserted mid-frame:
  - All buffers, counters and flags clear immediately.
  - The frame in progress is abandoned.
  - After release, output stays idle until a fresh axiiv rising edge.
- If axiiv is high at reset release, symbols are accepted from the first post-release edge as the start of a frame.

## Timing
- Reset values: axiov=0, axiod=0, axiolast=0, axioerr=0. Fill counter 0, select A, both drain states IDLE.
- All outputs are registered.
- Latency: word k's first input symbol at cycle t produces its first output symbol at cycle t+N. Fixed N-cycle latency per word.
- Output is gap-free for a frame of complete words: axiov high for exactly N·(full words) cycles.
- axiod holds 0 when axiov=0.
- axioerr asserts in the cycle after the first axiiv=0 sample that follows a partial word.
- axioerr is independent of axiov and may coincide with drain cycles.
- axiolast is high only when axiov is high.

## Structure
- Shared package contains:
  - the drain-state typedef (IDLE, DRAIN);
  - localparam helper CNT_W = $clog2(SYMS_PER_WORD) for fill and drain counters.
- One sub-module is natural: symbol_word_buf.
  - One N×SYM_W buffer with write index and registered read index plus order bit.
  - Instantiated twice.
- Target size: 150–250 lines RTL total.

## Test plan
- SYM_W=2, N=4, rev=1: input 00,01,10,11 then axiiv low → axiod 11,10,01,00 on cycles 4–7; axiolast on cycle 7; axioerr never.
- Same stimulus with rev=0 → output 00,01,10,11 on cycles 4–7, last on cycle 7.
- 8 symbols 0..3,3..0 with rev=1 → output 3,2,1,0 then 0,1,2,3 contiguous over cycles 4–11; axiolast only on cycle 11.
- 6 symbols 0,1,2,3,1,1 → first word output reversed (3,2,1,0); axiolast on its last symbol; axioerr pulses one cycle after axiiv falls; partial symbols never appear.
- Back-to-back frames with a one-cycle gap: frame 1 uses rev=1, frame 2 uses rev=0 → frame 1 drains reversed and frame 2 in order, with no lost or duplicated symbols.
- rst asserted asynchronously mid-word 2 → all outputs 0 in the same cycle; after release plus a new 4-symbol frame, only the new word is emitted.
- Parameter sweep SYM_W=8, N=3 with rev=1: bytes A1,B2,C3 → C3,B2,A1.
